// File: rtl/uart_receiver_top.sv
// UART receiver (8N1) feeding a small byte FIFO that drives a single
// active-low seven-segment digit. ASCII '0'..'9' are shown as digits and
// every other byte is shown as '-'.
module uart_receiver_top #(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxBit,
    output logic [6:0] sseg
);

    // Sample-tick divider, rounded to the nearest whole clock count.
    localparam int SAMPLE_RATE = BAUD * OVERSAMPLE;
    localparam int DIV_RAW     = (CLK_FREQ + SAMPLE_RATE / 2) / SAMPLE_RATE;
    localparam int DIV         = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W       = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    // Tick counting within one bit period.
    localparam int TICK_W = $clog2(OVERSAMPLE + 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

    // FIFO addressing; pointers carry one extra wrap bit.
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Byte to active-low segment pattern (bits g..a).
    function automatic logic [6:0] seg_decode(input logic [7:0] b);
        logic [6:0] p;
        case (b)
            8'h30:   p = 7'b1000000;
            8'h31:   p = 7'b1111001;
            8'h32:   p = 7'b0100100;
            8'h33:   p = 7'b0110000;
            8'h34:   p = 7'b0011001;
            8'h35:   p = 7'b0010010;
            8'h36:   p = 7'b0000010;
            8'h37:   p = 7'b1111000;
            8'h38:   p = 7'b0000000;
            8'h39:   p = 7'b0010000;
            default: p = SEG_DASH;
        endcase
        return p;
    endfunction

    logic              sync1_r;
    logic              sync2_r;
    logic              rx_s;
    logic [DIV_W-1:0]  div_cnt_r;
    logic              tick_s;

    state_t            state_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic [2:0]        bit_cnt_r;
    logic [7:0]        shift_r;
    logic              push_r;
    logic              armed_r;

    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic              full_s;
    logic              empty_s;
    logic              do_push_s;
    logic              do_pop_s;
    logic [6:0]        sseg_r;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= RxBit;
            sync2_r <= sync1_r;
        end
    end

    assign rx_s = sync2_r;

    // Free-running divider producing one sample tick every DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= '0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    assign tick_s = (div_cnt_r == DIV_LAST);

    // Receive FSM: start detect, mid-bit sampling, stop check and push pulse.
    // armed_r blocks a new start after a framing error until the line is seen high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            push_r     <= 1'b0;
            armed_r    <= 1'b1;
        end else begin
            push_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rx_s == 1'b1) begin
                        armed_r <= 1'b1;
                    end else if (armed_r) begin
                        tick_cnt_r <= '0;
                        state_r    <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        if (tick_cnt_r == HALF_LAST) begin
                            tick_cnt_r <= '0;
                            bit_cnt_r  <= 3'd0;
                            state_r    <= (rx_s == 1'b0) ? ST_DATA : ST_IDLE;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (tick_cnt_r == FULL_LAST) begin
                            tick_cnt_r <= '0;
                            shift_r    <= {rx_s, shift_r[7:1]};
                            if (bit_cnt_r == 3'd7) begin
                                state_r <= ST_STOP;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        if (tick_cnt_r == FULL_LAST) begin
                            tick_cnt_r <= '0;
                            if (rx_s == 1'b1) begin
                                push_r <= 1'b1;
                            end else begin
                                armed_r <= 1'b0;
                            end
                            state_r <= ST_IDLE;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_push_s = push_r && !full_s;
    assign do_pop_s  = !empty_s;

    // FIFO storage; a push into a full FIFO is ignored.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
        end
    end

    // FIFO pointers; push and pop in the same cycle both advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Display stage: decode the popped byte on the pop edge, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sseg_r <= SEG_BLANK;
        end else if (do_pop_s) begin
            sseg_r <= seg_decode(mem_r[rd_ptr_r[AW-1:0]]);
        end else begin
            sseg_r <= sseg_r;
        end
    end

    assign sseg = sseg_r;

endmodule

// File: tb/tb_uart_receiver_top.sv
// Directed and randomized bench for uart_receiver_top: serial frames are
// driven at 8680 ns/bit and the digit shown is compared with a lookup model.
`timescale 1ns/1ps
module tb_uart_receiver_top;

    localparam real CLK_HALF = 18.518;
    localparam real BIT_NS   = 8680.0;

    logic       clk;
    logic       rst;
    logic       RxBit;
    logic [6:0] sseg;

    int checks;
    int errors;

    uart_receiver_top #(
        .CLK_FREQ   (27000000),
        .BAUD       (115200),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .RxBit (RxBit),
        .sseg  (sseg)
    );

    initial clk = 1'b0;
    always #(CLK_HALF) clk = ~clk;

    // Reference: ASCII digit -> active-low pattern (g..a), anything else '-'.
    function automatic logic [6:0] model(input logic [7:0] b);
        logic [6:0] tab [10];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (b >= 8'h30 && b <= 8'h39) return tab[b - 8'h30];
        return 7'b0111111;
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        @(negedge clk);
        checks++;
        assert (sseg === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, sseg, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        RxBit = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            RxBit = b[i];
            #(BIT_NS);
        end
        RxBit = stop_val;
        #(BIT_NS);
        RxBit = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        logic [6:0] last;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        RxBit  = 1'b1;

        #1000;
        check("reset_blank", 7'b1111111);
        rst = 1'b0;
        #3000;
        check("idle_blank", 7'b1111111);

        // Frame 0x35 -> '5', then stays stable.
        send_frame(8'h35, 1'b1);
        check("frame_35", model(8'h35));
        #10000;
        check("frame_35_hold", model(8'h35));

        // 30 us later, 0x38 -> '8'.
        #30000;
        send_frame(8'h38, 1'b1);
        check("frame_38", model(8'h38));

        // 2 us glitch is rejected.
        #20000;
        RxBit = 1'b0;
        #2000;
        RxBit = 1'b1;
        #20000;
        check("glitch", model(8'h38));

        // Non-digit shows '-'.
        send_frame(8'h41, 1'b1);
        check("frame_41", model(8'h41));

        // Framing error: byte dropped, next valid frame displayed.
        #20000;
        send_frame(8'h35, 1'b0);
        #5000;
        check("framing_drop", model(8'h41));
        #20000;
        send_frame(8'h37, 1'b1);
        check("frame_37", model(8'h37));

        // Reset during data bit 4 aborts the frame.
        #20000;
        b = 8'h39;
        RxBit = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            RxBit = b[i];
            #(BIT_NS);
        end
        RxBit = b[4];
        #(BIT_NS / 2.0);
        rst   = 1'b1;
        RxBit = 1'b1;
        #10;
        check("rst_midframe", 7'b1111111);
        #1000;
        rst = 1'b0;
        #(3.0 * BIT_NS);
        check("rst_no_byte", 7'b1111111);
        send_frame(8'h30, 1'b1);
        check("frame_30", model(8'h30));

        // Randomized frames with random idle gaps.
        last = model(8'h30);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) b = 8'h30 + 8'($urandom_range(0, 9));
            else            b = 8'($urandom_range(0, 255));
            #($urandom_range(2000, 20000));
            send_frame(b, 1'b1);
            last = model(b);
            check($sformatf("rand_%0d_%02h", k, b), last);
        end
        #20000;
        check("final_hold", last);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
